// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  misalign;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Instruction memory req/gnt/rvalid bus between fetch and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small register FIFO of fetched entries; flush beats push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_push,
    input  wire T                     i_data,
    input  wire logic                 i_pop,
    input  wire logic                 i_flush,
    output T                          o_head,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    T                     r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage: one outstanding word read, FIFO buffer to decode.
//               Optional misaligned-PC fault entries: FETCH_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = FETCH_XLEN,
    parameter int DEPTH      = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [DATA_WIDTH-1:0] pc_i,
    input  wire logic                  flush_i,
    output logic                       pc_advance_o,
    instr_fetch_unit_if.master         mem,
    output logic                       instr_valid_o,
    input  wire logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0]      instr_o,
    output logic [DATA_WIDTH-1:0]      instr_pc_o,
    output logic                       instr_misalign_o
);

    fetch_state_e             r_state;
    fetch_state_e             w_state_nxt;
    logic [DATA_WIDTH-1:0]    r_req_pc;
    logic                     w_req;
    logic                     w_adv;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(DEPTH):0]   w_count;
    fetch_entry_t             w_push_entry;
    fetch_entry_t             w_head;
    logic                     w_unused_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req && mem.mem_gnt_i) begin
                r_req_pc <= pc_i;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req        = 1'b0;
        w_adv        = 1'b0;
        w_push       = 1'b0;
        w_push_entry = '0;
        unique case (r_state)
            IDLE: begin
`ifdef FETCH_MISALIGN_CHECK_EN
                if (pc_i[1:0] != 2'b00) begin
                    // Fault entry replaces the memory access; the PC still steps
                    if (!flush_i && !w_full) begin
                        w_push       = 1'b1;
                        w_push_entry = '{pc: pc_i, instr: NOP_INSTR, misalign: 1'b1};
                        w_adv        = 1'b1;
                    end
                end else
`endif
                begin
                    w_req = !flush_i && !w_full;
                    if (w_req && mem.mem_gnt_i) begin
                        w_adv       = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem.mem_rvalid_i) begin
                    w_state_nxt = IDLE;
                    if (!flush_i) begin
                        w_push       = 1'b1;
                        w_push_entry = '{pc: r_req_pc, instr: mem.mem_rdata_i, misalign: 1'b0};
                    end
                end else if (flush_i) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (mem.mem_rvalid_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset forces the state to IDLE, so the request must be masked explicitly
    assign mem.mem_req_o  = w_req && !rst;
    assign pc_advance_o   = w_adv && !rst;
    assign mem.mem_addr_o = {pc_i[DATA_WIDTH-1:2], 2'b00};

    assign w_pop = instr_valid_o && instr_ready_i;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (flush_i),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign instr_valid_o = !w_empty;
    assign instr_o       = w_head.instr;
    assign instr_pc_o    = w_head.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign instr_misalign_o = w_head.misalign;
    assign w_unused_bits    = ^w_count;
`else
    assign instr_misalign_o = 1'b0;
    assign w_unused_bits    = ^{w_count, w_head.misalign};
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Randomized bench for instr_fetch_unit with a PC/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pc_i;
    logic          flush_i;
    logic          pc_advance_o;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [DW-1:0] instr_o;
    logic [DW-1:0] instr_pc_o;
    logic          instr_misalign_o;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.DATA_WIDTH(DW)) mem_bus ();

    instr_fetch_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .flush_i          (flush_i),
        .pc_advance_o     (pc_advance_o),
        .mem              (mem_bus),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_misalign_o (instr_misalign_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
        int          cyc;
        int          min_lat;
    } exp_t;

    exp_t        q[$];          // every fetch not yet consumed, oldest first
    bit          pending;       // memory owes one response
    bit          live;          // that response will still be buffered
    int          resp_cnt;
    logic [31:0] resp_data;
    logic [31:0] next_pc;
    logic [31:0] flush_target;
    bit          force_flush;
    logic [31:0] force_target;
    bit          prev_hold;
    logic [31:0] prev_instr, prev_pc;
    int          cyc;
    int          p_gnt, p_ready, p_flush, min_d, max_d;
    bit          exact_lat;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'h0050_0093 : ((addr * 32'h9E37_79B1) ^ 32'h5A5A_0013);
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic step();
        logic        exp_req, exp_mis_adv, exp_adv, do_pop;
        logic [31:0] exp_addr;
        exp_t        e;
        int          lat;
        @(posedge clk);
        #1;
        pc_i = next_pc;
        mem_bus.mem_rvalid_i = 1'b0;
        mem_bus.mem_rdata_i  = $urandom;
        if (pending) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_bus.mem_rvalid_i = 1'b1;
                mem_bus.mem_rdata_i  = resp_data;
            end
        end
        mem_bus.mem_gnt_i = ($urandom_range(0, 99) < p_gnt);
        instr_ready_i     = ($urandom_range(0, 99) < p_ready);
        if (force_flush) begin
            flush_i      = 1'b1;
            flush_target = force_target;
            force_flush  = 1'b0;
        end else begin
            flush_i      = ($urandom_range(0, 99) < p_flush);
            flush_target = rand_target();
        end

        @(negedge clk);
        exp_addr = {pc_i[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_req     = !flush_i && !pending && (q.size() < DEPTH) && (pc_i[1:0] == 2'b00);
        exp_mis_adv = !flush_i && !pending && (q.size() < DEPTH) && (pc_i[1:0] != 2'b00);
`else
        exp_req     = !flush_i && !pending && (q.size() < DEPTH);
        exp_mis_adv = 1'b0;
`endif
        exp_adv = (exp_req && mem_bus.mem_gnt_i) || exp_mis_adv;
        check_eq("mem_req", mem_bus.mem_req_o, exp_req);
        check_eq("pc_advance", pc_advance_o, exp_adv);
        if (mem_bus.mem_req_o) check_eq("mem_addr", mem_bus.mem_addr_o, exp_addr);
        check_eq("instr_valid", instr_valid_o, (q.size() - int'(live)) > 0);
        if (prev_hold) begin
            check_eq("hold_instr", instr_o, prev_instr);
            check_eq("hold_pc", instr_pc_o, prev_pc);
        end

        do_pop = instr_valid_o && instr_ready_i && !flush_i;
        if (do_pop) begin
            if (q.size() == 0) begin
                check_eq("spurious_valid", instr_valid_o, 1'b0);
            end else begin
                e   = q.pop_front();
                lat = cyc - e.cyc;
                check_eq("instr", instr_o, e.instr);
                check_eq("instr_pc", instr_pc_o, e.pc);
                check_eq("misalign", instr_misalign_o, e.mis);
                if (exact_lat && !e.mis) check_eq("latency", lat, 2);
                else                     check_eq("latency_min", lat >= e.min_lat, 1'b1);
            end
        end

        if (mem_bus.mem_rvalid_i) begin
            pending = 1'b0;
            live    = 1'b0;
        end
        if (flush_i) begin
            q.delete();
            live = 1'b0;
        end
        if (exp_req && mem_bus.mem_gnt_i) begin
            q.push_back('{pc: pc_i, instr: word(exp_addr), mis: 1'b0, cyc: cyc, min_lat: 2});
            pending   = 1'b1;
            live      = 1'b1;
            resp_cnt  = $urandom_range(min_d, max_d);
            resp_data = word(exp_addr);
        end
        if (exp_mis_adv) q.push_back('{pc: pc_i, instr: NOP_INSTR, mis: 1'b1, cyc: cyc, min_lat: 1});

        next_pc    = flush_i ? flush_target : (exp_adv ? pc_i + 32'd4 : pc_i);
        prev_hold  = instr_valid_o && !instr_ready_i && !flush_i;
        prev_instr = instr_o;
        prev_pc    = instr_pc_o;
        cyc++;
    endtask

    task automatic quiet_inputs();
        flush_i              = 1'b0;
        instr_ready_i        = 1'b0;
        mem_bus.mem_gnt_i    = 1'b0;
        mem_bus.mem_rvalid_i = 1'b0;
        mem_bus.mem_rdata_i  = '0;
    endtask

    task automatic clear_model(input logic [31:0] start_pc);
        q.delete();
        pending   = 1'b0;
        live      = 1'b0;
        prev_hold = 1'b0;
        pc_i      = start_pc;
        next_pc   = start_pc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, mem_bus.mem_req_o, 1'b0);
        check_eq({tag, "_adv"}, pc_advance_o, 1'b0);
        check_eq({tag, "_valid"}, instr_valid_o, 1'b0);
        check_eq({tag, "_instr"}, instr_o, 32'h0);
        check_eq({tag, "_pc"}, instr_pc_o, 32'h0);
        check_eq({tag, "_mis"}, instr_misalign_o, 1'b0);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_grant(input int cnt_at_grant);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            seen = pending && (resp_cnt == cnt_at_grant);
        end
        check_eq("grant_seen", seen, 1'b1);
    endtask

    task automatic set_knobs(input int g, input int r, input int f, input int dmin, input int dmax);
        p_gnt   = g;
        p_ready = r;
        p_flush = f;
        min_d   = dmin;
        max_d   = dmax;
    endtask

    initial begin
        bit seen;
        cyc         = 0;
        force_flush = 1'b0;
        exact_lat   = 1'b0;
        rst         = 1'b1;
        quiet_inputs();
        clear_model(32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // back-to-back fetch with immediate response and a ready decoder
        set_knobs(100, 100, 0, 1, 1);
        exact_lat = 1'b1;
        run_random(20);
        exact_lat = 1'b0;

        // decoder stalls: FIFO fills, fetch stops, head held; then drains
        set_knobs(100, 0, 0, 1, 1);
        run_random(10);
        p_ready = 100;
        run_random(10);

        // redirect while a response is still outstanding
        set_knobs(100, 100, 0, 2, 2);
        wait_grant(2);
        force_flush  = 1'b1;
        force_target = 32'h0000_0100;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (mem_bus.mem_req_o) begin
                seen = 1'b1;
                check_eq("redirect_addr", mem_bus.mem_addr_o, 32'h0000_0100);
            end
        end
        check_eq("redirect_req_seen", seen, 1'b1);

        set_knobs(70, 60, 6, 1, 3);
        run_random(1500);

        // asynchronous reset in the middle of an outstanding read
        set_knobs(100, 50, 0, 3, 3);
        wait_grant(3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        quiet_inputs();
        clear_model(32'h0000_0200);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("post_rst_req", mem_bus.mem_req_o, 1'b1);
        check_eq("post_rst_addr", mem_bus.mem_addr_o, 32'h0000_0200);

        set_knobs(60, 70, 5, 1, 3);
        run_random(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
